zilla_instr_mem: RTL and testbench

Single-port synchronous instruction memory that sits directly upstream of the program-control top. It serves fetch reads issued by the PC-update stage and returns the instruction word one cycle later, with a valid strobe that feeds the instruction buffer. It also gives the debug module read/write access, with byte strobes, while the hart is halted. It flags out-of-range fetch and debug addresses.

---
 rtl/zilla_instr_mem.sv | 157 +++++++++++++++
 tb/tb_zilla_instr_mem.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zilla_instr_mem.sv
`default_nettype none
// ============================================================================
// Module   : zilla_instr_mem
// Brief    : Single-port instruction memory: 1-cycle fetch port for PC update,
//            byte-strobed debug read/write port while the hart is halted.
// Revision : 1.0 - initial release
// ============================================================================
module zilla_instr_mem #(
    parameter int                           DATA_WIDTH        = 32,
    parameter int                           INSTRUCTION_WIDTH = 32,
    parameter int                           PC_WIDTH          = 32,
    parameter int                           MEM_DEPTH         = 1024,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR         = 32'h0000_0013
) (
    input  logic                         z_clk,
    input  logic                         z_rst,
    input  logic                         wdt_reset_i,
    input  logic                         instr_read_enable_i,
    input  logic [PC_WIDTH-1:0]          instr_read_addr_i,
    input  logic                         flush_i,
    input  logic                         debug_mode_valid_i,
    input  logic                         debug_mem_read_enable_i,
    input  logic [DATA_WIDTH-1:0]        debug_mem_read_addr_i,
    input  logic                         debug_mem_write_enable_i,
    input  logic [DATA_WIDTH-1:0]        debug_mem_write_addr_i,
    input  logic [DATA_WIDTH-1:0]        debug_mem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]      debug_mem_strobe_i,
    output logic [INSTRUCTION_WIDTH-1:0] z_instruction_o,
    output logic                         z_instruction_valid_o,
    output logic                         instr_addr_invalid_o,
    output logic [DATA_WIDTH-1:0]        debug_mem_rdata_o,
    output logic                         debug_mem_rvalid_o,
    output logic                         debug_access_err_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int LANES = DATA_WIDTH / 8;

    logic [INSTRUCTION_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [INSTRUCTION_WIDTH-1:0] instr_q,  instr_d;
    logic                         ivalid_q, ivalid_d;
    logic                         iinv_q,   iinv_d;
    logic [DATA_WIDTH-1:0]        rdata_q,  rdata_d;
    logic                         rvalid_q, rvalid_d;
    logic                         err_q,    err_d;

    logic [IDX_W-1:0] w_fetch_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_fetch_in_range;
    logic             w_rd_in_range;
    logic             w_wr_in_range;
    logic             w_dbg_wr_go;
    logic             w_unused_lsbs;

    // Byte addresses: bits [1:0] are ignored, anything above the index must be zero.
    assign w_fetch_idx      = instr_read_addr_i[IDX_W+1:2];
    assign w_rd_idx         = debug_mem_read_addr_i[IDX_W+1:2];
    assign w_wr_idx         = debug_mem_write_addr_i[IDX_W+1:2];
    assign w_fetch_in_range = (instr_read_addr_i >> (IDX_W + 2)) == '0;
    assign w_rd_in_range    = (debug_mem_read_addr_i >> (IDX_W + 2)) == '0;
    assign w_wr_in_range    = (debug_mem_write_addr_i >> (IDX_W + 2)) == '0;
    assign w_unused_lsbs    = &{1'b0, instr_read_addr_i[1:0],
                                debug_mem_read_addr_i[1:0], debug_mem_write_addr_i[1:0]};

    always_comb begin
        instr_d     = instr_q;
        ivalid_d    = 1'b0;
        iinv_d      = 1'b0;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        w_dbg_wr_go = 1'b0;

        if (!debug_mode_valid_i) begin
            if (instr_read_enable_i) begin
                ivalid_d = 1'b1;
                if (w_fetch_in_range) begin
                    instr_d = mem_q[w_fetch_idx];
                end else begin
                    instr_d = NOP_INSTR;
                    iinv_d  = 1'b1;
                end
            end
            if (debug_mem_read_enable_i || debug_mem_write_enable_i) begin
                err_d = 1'b1;
            end
        end else begin
            if (debug_mem_write_enable_i) begin
                if (w_wr_in_range) begin
                    w_dbg_wr_go = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            // Single port: a read colliding with a write always loses.
            if (debug_mem_read_enable_i) begin
                if (debug_mem_write_enable_i) begin
                    err_d = 1'b1;
                end else if (w_rd_in_range) begin
                    rdata_d  = mem_q[w_rd_idx];
                    rvalid_d = 1'b1;
                end else begin
                    rdata_d  = '0;
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge z_clk) begin
        if (w_dbg_wr_go) begin
            for (int b = 0; b < LANES; b++) begin
                if (debug_mem_strobe_i[b]) begin
                    mem_q[w_wr_idx][8*b +: 8] <= debug_mem_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge z_clk or negedge z_rst) begin
        if (!z_rst) begin
            instr_q  <= NOP_INSTR;
            ivalid_q <= 1'b0;
            iinv_q   <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (wdt_reset_i) begin
            instr_q  <= NOP_INSTR;
            ivalid_q <= 1'b0;
            iinv_q   <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            ivalid_q <= ivalid_d;
            iinv_q   <= iinv_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // A flush in the response cycle kills the strobe and the error, not the data.
    assign z_instruction_o       = instr_q;
    assign z_instruction_valid_o = ivalid_q & ~flush_i;
    assign instr_addr_invalid_o  = iinv_q & ~flush_i;
    assign debug_mem_rdata_o     = rdata_q;
    assign debug_mem_rvalid_o    = rvalid_q;
    assign debug_access_err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_zilla_instr_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_zilla_instr_mem
// Brief    : Directed + randomized bench for zilla_instr_mem against an
//            array-based reference model of the memory and its ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zilla_instr_mem;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] LIMIT = DEPTH * 4;

    logic        z_clk = 1'b0;
    logic        z_rst;
    logic        wdt_reset_i;
    logic        instr_read_enable_i;
    logic [31:0] instr_read_addr_i;
    logic        flush_i;
    logic        debug_mode_valid_i;
    logic        debug_mem_read_enable_i;
    logic [31:0] debug_mem_read_addr_i;
    logic        debug_mem_write_enable_i;
    logic [31:0] debug_mem_write_addr_i;
    logic [31:0] debug_mem_wdata_i;
    logic [3:0]  debug_mem_strobe_i;
    logic [31:0] z_instruction_o;
    logic        z_instruction_valid_o;
    logic        instr_addr_invalid_o;
    logic [31:0] debug_mem_rdata_o;
    logic        debug_mem_rvalid_o;
    logic        debug_access_err_o;

    zilla_instr_mem dut (
        .z_clk                    (z_clk),
        .z_rst                    (z_rst),
        .wdt_reset_i              (wdt_reset_i),
        .instr_read_enable_i      (instr_read_enable_i),
        .instr_read_addr_i        (instr_read_addr_i),
        .flush_i                  (flush_i),
        .debug_mode_valid_i       (debug_mode_valid_i),
        .debug_mem_read_enable_i  (debug_mem_read_enable_i),
        .debug_mem_read_addr_i    (debug_mem_read_addr_i),
        .debug_mem_write_enable_i (debug_mem_write_enable_i),
        .debug_mem_write_addr_i   (debug_mem_write_addr_i),
        .debug_mem_wdata_i        (debug_mem_wdata_i),
        .debug_mem_strobe_i       (debug_mem_strobe_i),
        .z_instruction_o          (z_instruction_o),
        .z_instruction_valid_o    (z_instruction_valid_o),
        .instr_addr_invalid_o     (instr_addr_invalid_o),
        .debug_mem_rdata_o        (debug_mem_rdata_o),
        .debug_mem_rvalid_o       (debug_mem_rvalid_o),
        .debug_access_err_o       (debug_access_err_o)
    );

    always #5 z_clk = ~z_clk;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_instr;
    logic        exp_iv;
    logic        exp_ii;
    logic [31:0] exp_rdata;
    logic        exp_rv;
    logic        exp_err;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " instr"},   z_instruction_o,              exp_instr);
        chk({tag, " ivalid"},  32'(z_instruction_valid_o),   32'(exp_iv & ~flush_i));
        chk({tag, " iinv"},    32'(instr_addr_invalid_o),    32'(exp_ii & ~flush_i));
        chk({tag, " rdata"},   debug_mem_rdata_o,            exp_rdata);
        chk({tag, " rvalid"},  32'(debug_mem_rvalid_o),      32'(exp_rv));
        chk({tag, " err"},     32'(debug_access_err_o),      32'(exp_err));
    endtask

    task automatic model_reset();
        exp_instr = NOP;
        exp_iv    = 1'b0;
        exp_ii    = 1'b0;
        exp_rdata = 32'h0;
        exp_rv    = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic idle();
        wdt_reset_i              = 1'b0;
        instr_read_enable_i      = 1'b0;
        instr_read_addr_i        = 32'h0;
        flush_i                  = 1'b0;
        debug_mem_read_enable_i  = 1'b0;
        debug_mem_read_addr_i    = 32'h0;
        debug_mem_write_enable_i = 1'b0;
        debug_mem_write_addr_i   = 32'h0;
        debug_mem_wdata_i        = 32'h0;
        debug_mem_strobe_i       = 4'h0;
    endtask

    // Predict the response to the inputs currently applied, clock once, then compare.
    task automatic tick(input string tag);
        logic [31:0] n_instr = exp_instr;
        logic [31:0] n_rdata = exp_rdata;
        logic        n_iv = 1'b0, n_ii = 1'b0, n_rv = 1'b0, n_err = 1'b0, do_wr = 1'b0;
        if (!debug_mode_valid_i) begin
            if (instr_read_enable_i) begin
                n_iv = 1'b1;
                if (instr_read_addr_i < LIMIT) n_instr = ref_mem[instr_read_addr_i / 4];
                else begin n_instr = NOP; n_ii = 1'b1; end
            end
            n_err = debug_mem_read_enable_i | debug_mem_write_enable_i;
        end else begin
            if (debug_mem_write_enable_i) begin
                if (debug_mem_write_addr_i < LIMIT) do_wr = 1'b1;
                else n_err = 1'b1;
            end
            if (debug_mem_read_enable_i) begin
                if (debug_mem_write_enable_i) n_err = 1'b1;
                else if (debug_mem_read_addr_i < LIMIT) begin
                    n_rdata = ref_mem[debug_mem_read_addr_i / 4];
                    n_rv    = 1'b1;
                end else begin
                    n_rdata = 32'h0; n_rv = 1'b1; n_err = 1'b1;
                end
            end
        end
        @(posedge z_clk);
        if (do_wr) begin
            for (int b = 0; b < 4; b++)
                if (debug_mem_strobe_i[b])
                    ref_mem[debug_mem_write_addr_i / 4][8*b +: 8] = debug_mem_wdata_i[8*b +: 8];
        end
        if (wdt_reset_i) model_reset();
        else begin
            exp_instr = n_instr; exp_iv = n_iv; exp_ii = n_ii;
            exp_rdata = n_rdata; exp_rv = n_rv; exp_err = n_err;
        end
        #1;
        check_all(tag);
    endtask

    task automatic dbg_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        idle();
        debug_mode_valid_i       = 1'b1;
        debug_mem_write_enable_i = 1'b1;
        debug_mem_write_addr_i   = a;
        debug_mem_wdata_i        = d;
        debug_mem_strobe_i       = s;
        tick("dbg_write");
    endtask

    task automatic dbg_read(input logic [31:0] a);
        idle();
        debug_mode_valid_i      = 1'b1;
        debug_mem_read_enable_i = 1'b1;
        debug_mem_read_addr_i   = a;
        tick("dbg_read");
    endtask

    task automatic fetch(input logic [31:0] a);
        idle();
        debug_mode_valid_i  = 1'b0;
        instr_read_enable_i = 1'b1;
        instr_read_addr_i   = a;
        tick("fetch");
    endtask

    function automatic logic [31:0] pick_addr();
        int unsigned r = $urandom_range(0, 19);
        if (r == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        if (r < 3)  return LIMIT + 32'($urandom_range(0, 255));
        return 32'($urandom_range(0, 255));
    endfunction

    initial begin
        idle();
        debug_mode_valid_i = 1'b0;
        z_rst = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        z_rst = 1'b1;

        // Known contents everywhere so every later read has a defined expectation.
        for (int i = 0; i < DEPTH; i++) dbg_write(32'(i * 4), $urandom, 4'hF);
        dbg_write(32'h14, 32'h00A0_0093, 4'hF);
        dbg_write(32'h08, 32'h1122_3344, 4'hF);

        fetch(32'h14);
        chk("tp1 data", z_instruction_o, 32'h00A0_0093);
        chk("tp1 valid", 32'(z_instruction_valid_o), 32'd1);
        idle(); tick("tp1 hold");
        chk("tp1 held data", z_instruction_o, 32'h00A0_0093);
        chk("tp1 valid low", 32'(z_instruction_valid_o), 32'd0);

        fetch(32'h1000);
        chk("tp2 nop", z_instruction_o, NOP);
        chk("tp2 invalid", 32'(instr_addr_invalid_o), 32'd1);
        idle(); tick("tp2 after");
        chk("tp2 invalid drop", 32'(instr_addr_invalid_o), 32'd0);

        dbg_write(32'h08, 32'hDEAD_BEEF, 4'b0101);
        dbg_read(32'h08);
        chk("tp3 merged", debug_mem_rdata_o, 32'h11AD_33EF);
        chk("tp3 rvalid", 32'(debug_mem_rvalid_o), 32'd1);

        idle();
        debug_mode_valid_i       = 1'b0;
        debug_mem_write_enable_i = 1'b1;
        debug_mem_write_addr_i   = 32'h08;
        debug_mem_wdata_i        = 32'h0;
        debug_mem_strobe_i       = 4'hF;
        tick("tp4 rejected write");
        chk("tp4 err", 32'(debug_access_err_o), 32'd1);
        dbg_read(32'h08);
        chk("tp4 unchanged", debug_mem_rdata_o, 32'h11AD_33EF);
        idle();
        debug_mode_valid_i  = 1'b1;
        instr_read_enable_i = 1'b1;
        instr_read_addr_i   = 32'h14;
        tick("tp4 fetch in debug");
        chk("tp4 no fetch valid", 32'(z_instruction_valid_o), 32'd0);

        fetch(32'h1004);
        flush_i = 1'b1;
        #1;
        check_all("tp5 flushed");
        chk("tp5 valid killed", 32'(z_instruction_valid_o), 32'd0);
        tick("tp5 flush idle");
        flush_i = 1'b0;

        idle();
        debug_mode_valid_i       = 1'b1;
        debug_mem_read_enable_i  = 1'b1;
        debug_mem_read_addr_i    = 32'h14;
        debug_mem_write_enable_i = 1'b1;
        debug_mem_write_addr_i   = 32'h20;
        debug_mem_wdata_i        = 32'hCAFE_F00D;
        debug_mem_strobe_i       = 4'hF;
        tick("tp6 collide");
        chk("tp6 rvalid", 32'(debug_mem_rvalid_o), 32'd0);
        chk("tp6 err", 32'(debug_access_err_o), 32'd1);
        debug_mem_read_addr_i = 32'h20;
        debug_mem_write_addr_i = 32'h20;
        debug_mem_wdata_i     = 32'h1234_5678;
        tick("tp6 same word");
        dbg_read(32'h20);
        chk("tp6 landed", debug_mem_rdata_o, 32'h1234_5678);

        fetch(32'h14);
        debug_mode_valid_i = 1'b1;
        #1;
        check_all("fetch survives debug entry");
        dbg_read(32'h14);
        debug_mode_valid_i = 1'b0;
        #1;
        check_all("read survives debug exit");

        fetch(32'h14);
        idle();
        #2 z_rst = 1'b0;
        #1;
        model_reset();
        check_all("tp7 async reset");
        #1 z_rst = 1'b1;
        tick("tp7 after release");

        idle();
        wdt_reset_i         = 1'b1;
        instr_read_enable_i = 1'b1;
        instr_read_addr_i   = 32'h14;
        tick("tp8 wdt");
        chk("tp8 nop", z_instruction_o, NOP);
        dbg_read(32'h14);
        chk("tp8 preserved", debug_mem_rdata_o, 32'h00A0_0093);

        for (int n = 0; n < 400; n++) begin
            idle();
            debug_mode_valid_i       = 1'($urandom_range(0, 1));
            instr_read_enable_i      = 1'($urandom_range(0, 1));
            instr_read_addr_i        = pick_addr();
            flush_i                  = ($urandom_range(0, 4) == 0);
            debug_mem_read_enable_i  = ($urandom_range(0, 2) == 0);
            debug_mem_read_addr_i    = pick_addr();
            debug_mem_write_enable_i = ($urandom_range(0, 2) == 0);
            debug_mem_write_addr_i   = pick_addr();
            debug_mem_wdata_i        = $urandom;
            debug_mem_strobe_i       = 4'($urandom_range(0, 15));
            wdt_reset_i              = ($urandom_range(0, 49) == 0);
            if (wdt_reset_i) debug_mem_write_enable_i = 1'b0;
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
